// File: rtl/dfe_comp_pkg.sv
// Shared types and constants for the compensation-FIR reconfiguration controller.
package dfe_comp_pkg;

  localparam int unsigned W           = 16;
  localparam int unsigned MAX_TAPS    = 22;
  localparam int unsigned CntW        = 5;
  localparam int unsigned DecimSelMax = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StSettle
  } state_e;

  // Compensation FIR length for decimation 2^k: the D=2 variant is one tap shorter.
  function automatic logic [CntW-1:0] ntaps(input logic [2:0] k);
    return (k == 3'd1) ? CntW'(21) : CntW'(22);
  endfunction

endpackage

// File: rtl/comp_fir_reconfig_ctrl_if.sv
// Configuration, sample and FIR-side signals of the reconfiguration controller.
interface comp_fir_reconfig_ctrl_if #(
  parameter int unsigned W = dfe_comp_pkg::W
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [2:0]          cfg_decim_sel;
  logic                cfg_comp_en;
  logic                in_valid;
  logic signed [W-1:0] in_sample;
  logic                fir_in_valid;
  logic signed [W-1:0] fir_in_sample;
  logic [2:0]          fir_decim_sel;
  logic                fir_enable;
  logic                fir_out_valid;
  logic                out_valid;
  logic                busy;
  logic [7:0]          drop_cnt;

  modport master (
    output cfg_valid, cfg_decim_sel, cfg_comp_en, in_valid, in_sample, fir_out_valid,
    input  cfg_ready, fir_in_valid, fir_in_sample, fir_decim_sel, fir_enable, out_valid,
           busy, drop_cnt
  );

  modport slave (
    input  cfg_valid, cfg_decim_sel, cfg_comp_en, in_valid, in_sample, fir_out_valid,
    output cfg_ready, fir_in_valid, fir_in_sample, fir_decim_sel, fir_enable, out_valid,
           busy, drop_cnt
  );
endinterface

// File: rtl/dfe_load_downcounter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module dfe_load_downcounter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/comp_fir_reconfig_ctrl.sv
// Sequences a compensation-FIR reconfiguration: flush the delay line with zeros,
// then mask FIR outputs until the new taps have fully settled.
module comp_fir_reconfig_ctrl
  import dfe_comp_pkg::*;
#(
  parameter int unsigned W        = dfe_comp_pkg::W,
  parameter int unsigned MAX_TAPS = dfe_comp_pkg::MAX_TAPS
) (
  input logic                          clk,
  input logic                          rst_n,
  input logic                          clk_enable,
  comp_fir_reconfig_ctrl_if.slave      bus
);

  localparam logic [CntW-1:0] FlushLoad = CntW'(MAX_TAPS);

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic            en_q, en_d;
  logic [7:0]      drop_q, drop_d;

  logic [CntW-1:0] flush_cnt, mask_cnt, mask_load_val;
  logic            flush_zero, mask_zero;
  logic            cfg_ready, accept, bypass;
  logic [2:0]      sel_clamped;
  logic            flush_load, flush_dec, mask_load, mask_dec;
  logic            fir_in_valid;
  logic [W-1:0]    fir_in_sample;

  assign cfg_ready   = (state_q == StIdle);
  assign accept      = clk_enable & bus.cfg_valid & cfg_ready;
  assign sel_clamped = (bus.cfg_decim_sel > 3'(DecimSelMax)) ? 3'(DecimSelMax)
                                                              : bus.cfg_decim_sel;
  assign bypass      = ~bus.cfg_comp_en | (sel_clamped == 3'd0);

  assign flush_load    = accept & ~bypass;
  assign flush_dec     = clk_enable & (state_q == StFlush) & ~flush_zero;
  assign mask_load     = clk_enable & (state_q == StFlush) & (flush_cnt == CntW'(1));
  assign mask_load_val = ntaps(sel_q) - CntW'(1);
  assign mask_dec      = clk_enable & (state_q == StSettle) & bus.fir_out_valid & ~mask_zero;

  dfe_load_downcounter #(
    .Width (CntW)
  ) u_flush_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (flush_load),
    .load_val_i (FlushLoad),
    .dec_i      (flush_dec),
    .cnt_o      (flush_cnt),
    .zero_o     (flush_zero)
  );

  dfe_load_downcounter #(
    .Width (CntW)
  ) u_mask_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (mask_load),
    .load_val_i (mask_load_val),
    .dec_i      (mask_dec),
    .cnt_o      (mask_cnt),
    .zero_o     (mask_zero)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    en_d          = en_q;
    drop_d        = drop_q;
    fir_in_valid  = bus.in_valid & clk_enable;
    fir_in_sample = bus.in_sample;

    unique case (state_q)
      StIdle: begin
        // A sample coinciding with accept still goes out under the old config.
        if (accept) begin
          sel_d  = sel_clamped;
          en_d   = bus.cfg_comp_en;
          drop_d = '0;
          if (!bypass) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        fir_in_valid  = clk_enable;
        fir_in_sample = '0;
        if (clk_enable) begin
          if (bus.in_valid && (drop_q != 8'hff)) begin
            drop_d = drop_q + 8'd1;
          end
          if (flush_cnt == CntW'(1)) begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (mask_dec && (mask_cnt == CntW'(1))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      en_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.cfg_ready     = cfg_ready;
  assign bus.busy          = ~cfg_ready;
  assign bus.fir_in_valid  = fir_in_valid;
  assign bus.fir_in_sample = fir_in_sample;
  assign bus.fir_decim_sel = sel_q;
  assign bus.fir_enable    = en_q;
  assign bus.drop_cnt      = drop_q;
  assign bus.out_valid     = bus.fir_out_valid & clk_enable & mask_zero;

endmodule

// File: tb/tb_comp_fir_reconfig_ctrl.sv
// Directed bench for comp_fir_reconfig_ctrl with a cycle-level behavioural model.
module tb_comp_fir_reconfig_ctrl;

  localparam int MaxTaps = 22;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  always #5 clk = ~clk;

  comp_fir_reconfig_ctrl_if bus ();

  comp_fir_reconfig_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (ce),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: remaining flush cycles, remaining masked FIR outputs, drop count, config.
  typedef struct packed {
    int f;
    int m;
    int d;
    int s;
    int e;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t model_step(input mdl_t cur, input bit cv, input int cs,
                                      input bit cen, input bit iv, input bit fov);
    mdl_t nx;
    bit   acc;
    int   dec_factor;
    nx  = cur;
    acc = cv && (cur.f == 0) && (cur.m == 0);
    if (cur.f > 0) begin
      if (iv && nx.d < 255) nx.d = nx.d + 1;
      nx.f = cur.f - 1;
      if (nx.f == 0) begin
        dec_factor = 1 << cur.s;
        nx.m = ((dec_factor == 2) ? 21 : 22) - 1;
      end
    end else if (cur.m > 0 && fov) begin
      nx.m = cur.m - 1;
    end
    if (acc) begin
      nx.s = (cs > 4) ? 4 : cs;
      nx.e = cen ? 1 : 0;
      nx.d = 0;
      if (cen && nx.s != 0) nx.f = MaxTaps;
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl <= '0;
    end else if (ce) begin
      mdl <= model_step(mdl, bus.cfg_valid, int'(bus.cfg_decim_sel), bus.cfg_comp_en,
                        bus.in_valid, bus.fir_out_valid);
    end
  end

  always @(negedge clk) begin
    chk("cfg_ready", bus.cfg_ready, !(mdl.f > 0 || mdl.m > 0));
    chk("busy", bus.busy, (mdl.f > 0 || mdl.m > 0));
    chk("fir_in_valid", bus.fir_in_valid, ce && (mdl.f > 0 || bus.in_valid));
    chk("fir_in_sample", bus.fir_in_sample, (mdl.f > 0) ? 16'sd0 : bus.in_sample);
    chk("out_valid", bus.out_valid, bus.fir_out_valid && ce && (mdl.m == 0));
    chk("fir_decim_sel", bus.fir_decim_sel, mdl.s);
    chk("fir_enable", bus.fir_enable, mdl.e);
    chk("drop_cnt", bus.drop_cnt, mdl.d);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input int sel, input int en);
    bus.cfg_valid     = 1'b1;
    bus.cfg_decim_sel = 3'(sel);
    bus.cfg_comp_en   = (en != 0);
  endtask

  // Counts cycles (including clk_enable-low ones) until the first enabled non-flush cycle.
  task automatic count_flush(output int n, input int lo_at);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      look();
      if (ce && !(bus.fir_in_valid === 1'b1 && bus.fir_in_sample == 16'sd0 &&
                  bus.busy === 1'b1)) break;
      n++;
      nxt();
      ce = (lo_at < 0) || (n < lo_at) || (n >= lo_at + 5);
    end
  endtask

  // Offers fir_out_valid every cycle; counts how many are masked before one passes.
  task automatic count_mask(output int masked);
    nxt();
    bus.fir_out_valid = 1'b1;
    masked = 0;
    for (int i = 0; i < 40; i++) begin
      look();
      if (bus.out_valid === 1'b1) break;
      masked++;
      nxt();
    end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int masked;
    rst_n             = 1'b0;
    ce                = 1'b1;
    bus.cfg_valid     = 1'b0;
    bus.cfg_decim_sel = 3'd0;
    bus.cfg_comp_en   = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_sample     = '0;
    bus.fir_out_valid = 1'b0;

    repeat (3) nxt();
    look();
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sel", bus.fir_decim_sel, 0);
    chk("rst_en", bus.fir_enable, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    nxt();
    rst_n = 1'b1;

    // sel=1 (D=2): coincident sample passes under old config, 22 flush, 20 masked
    nxt();
    offer(1, 1);
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sh1234;
    look();
    chk("coincident_valid", bus.fir_in_valid, 1);
    chk("coincident_sample", bus.fir_in_sample, 16'h1234);
    chk("coincident_old_en", bus.fir_enable, 0);
    nxt();
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    count_flush(n, -1);
    chk("flush_len_sel1", n, 22);
    chk("sel1_applied", bus.fir_decim_sel, 1);
    count_mask(masked);
    chk("mask_sel1", masked, 20);
    chk("idle_after_mask", bus.busy, 0);

    // sel=7 clamps to 4; in_valid every flush cycle is dropped
    nxt();
    bus.fir_out_valid = 1'b0;
    offer(7, 1);
    look();
    nxt();
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sh7fff;
    count_flush(n, -1);
    chk("flush_len_sel7", n, 22);
    chk("sel_clamped", bus.fir_decim_sel, 4);
    chk("drop_22", bus.drop_cnt, 22);
    bus.in_valid = 1'b0;
    count_mask(masked);
    chk("mask_sel4", masked, 21);

    // bypass accept: stays idle, clears drop_cnt, out_valid follows fir_out_valid
    nxt();
    bus.fir_out_valid = 1'b0;
    offer(3, 0);
    look();
    chk("drop_before_clear", bus.drop_cnt, 22);
    nxt();
    bus.cfg_valid = 1'b0;
    look();
    chk("bypass_drop_clr", bus.drop_cnt, 0);
    chk("bypass_busy", bus.busy, 0);
    chk("bypass_sel", bus.fir_decim_sel, 3);
    chk("bypass_en", bus.fir_enable, 0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      bus.fir_out_valid = (i % 2 == 1);
      look();
      chk("bypass_out", bus.out_valid, (i % 2 == 1));
      chk("bypass_idle", bus.busy, 0);
    end

    // clk_enable low for 5 cycles mid-flush stretches it to 27 cycles
    nxt();
    bus.fir_out_valid = 1'b0;
    offer(2, 1);
    look();
    nxt();
    bus.cfg_valid = 1'b0;
    count_flush(n, 10);
    chk("flush_len_ce_gap", n, 27);

    // request held through settle is taken right after busy falls
    offer(1, 1);
    count_mask(masked);
    chk("mask_sel2", masked, 21);
    chk("held_ready", bus.cfg_ready, 1);
    nxt();
    bus.cfg_valid     = 1'b0;
    bus.fir_out_valid = 1'b0;
    count_flush(n, -1);
    chk("held_flush_len", n, 22);
    chk("held_sel", bus.fir_decim_sel, 1);

    // asynchronous reset mid-settle
    nxt();
    bus.fir_out_valid = 1'b1;
    repeat (5) begin
      look();
      nxt();
    end
    look();
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.cfg_ready, 1);
    chk("arst_sel", bus.fir_decim_sel, 0);
    chk("arst_en", bus.fir_enable, 0);
    chk("arst_drop", bus.drop_cnt, 0);
    bus.fir_out_valid = 1'b0;
    nxt();
    rst_n = 1'b1;
    offer(4, 1);
    look();
    chk("post_rst_ready", bus.cfg_ready, 1);
    nxt();
    bus.cfg_valid = 1'b0;
    look();
    chk("post_rst_accept", bus.busy, 1);
    chk("post_rst_sel", bus.fir_decim_sel, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
